button_debouncer: RTL and testbench

Input-side companion to the LED blink driver: conditions up to `N` raw active-low push-buttons/switches on the board into clean, `sys_clk`-synchronous signals. For each button it provides:
- a debounced level;
- single-cycle press and release strobes;
- a single-cycle long-press strobe.

It sits between the board pins and any control logic, for example logic that selects LED patterns or blink periods.

---
 rtl/button_debouncer.sv | 88 ++++++++
 tb/tb_button_debouncer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Conditions N raw active-low buttons into synchronous debounced levels plus
// one-cycle press, release and long-press strobes.
module button_debouncer #(
  parameter int N               = 8,
  parameter int DEBOUNCE_CYCLES = 600000,
  parameter int LONG_CYCLES     = 12000000
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic [N-1:0] btn_n,
  output logic [N-1:0] state,
  output logic [N-1:0] press,
  // "release" is a reserved word, hence the suffix
  output logic [N-1:0] release_pulse,
  output logic [N-1:0] long_press
);

  localparam logic [19:0] DC_LAST = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0] HC_LAST = 24'(LONG_CYCLES - 1);
  localparam logic [23:0] HC_SAT  = 24'(LONG_CYCLES);

  logic [N-1:0] sync_p0;
  logic [N-1:0] sync_p1;
  logic [N-1:0] s;
  logic [19:0]  dc [N];
  logic [23:0]  hc [N];

  function automatic logic [23:0] hold_sat_inc(input logic [23:0] v);
    return (v == HC_SAT) ? v : v + 24'd1;
  endfunction

  // Stage p0/p1: two-flop synchronizer, resets to released (pins high)
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
    end else begin
      sync_p0 <= btn_n;
      sync_p1 <= sync_p0;
    end
  end

  assign s = ~sync_p1;

  // Debounce stage: any sample equal to the current level restarts the count
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state         <= '0;
      press         <= '0;
      release_pulse <= '0;
      for (int i = 0; i < N; i++) dc[i] <= '0;
    end else begin
      press         <= '0;
      release_pulse <= '0;
      for (int i = 0; i < N; i++) begin
        if (s[i] == state[i]) begin
          dc[i] <= '0;
        end else if (dc[i] == DC_LAST) begin
          state[i]         <= s[i];
          dc[i]            <= '0;
          press[i]         <= s[i];
          release_pulse[i] <= ~s[i];
        end else begin
          dc[i] <= dc[i] + 20'd1;
        end
      end
    end
  end

  // Hold stage: counter parks one past the threshold so the strobe fires once
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      long_press <= '0;
      for (int i = 0; i < N; i++) hc[i] <= '0;
    end else begin
      long_press <= '0;
      for (int i = 0; i < N; i++) begin
        if (!state[i]) begin
          hc[i] <= '0;
        end else begin
          hc[i]         <= hold_sat_inc(hc[i]);
          long_press[i] <= (hc[i] == HC_LAST);
        end
      end
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with N=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=10.
module tb_button_debouncer;

  localparam int N  = 2;
  localparam int DC = 4;
  localparam int LC = 10;

  logic         sys_clk = 1'b0;
  logic         sys_rst = 1'b1;
  logic [N-1:0] btn_n   = 2'b11;
  logic [N-1:0] state;
  logic [N-1:0] press;
  logic [N-1:0] release_pulse;
  logic [N-1:0] long_press;

  int vectors     = 0;
  int miscompares = 0;

  button_debouncer #(
    .N              (N),
    .DEBOUNCE_CYCLES(DC),
    .LONG_CYCLES    (LC)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .btn_n        (btn_n),
    .state        (state),
    .press        (press),
    .release_pulse(release_pulse),
    .long_press   (long_press)
  );

  always #5 sys_clk = ~sys_clk;

  // Observed bundle: {state, press, release, long_press}, two bits each
  task automatic test_reset();
    logic [7:0] exp;
    btn_n = 2'b00;
    #2 sys_rst = 1'b0;
    #1;
    vectors++;
    if ({state, press, release_pulse, long_press} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_async got %b want %b", {state, press, release_pulse, long_press}, 8'h00);
    end
    repeat (3) begin
      @(negedge sys_clk);
      vectors++;
      if ({state, press, release_pulse, long_press} !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_hold got %b want %b", {state, press, release_pulse, long_press}, 8'h00);
      end
    end
    sys_rst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge sys_clk);
      exp = {(k >= 6) ? 2'b11 : 2'b00, (k == 6) ? 2'b11 : 2'b00, 2'b00, 2'b00};
      vectors++;
      if ({state, press, release_pulse, long_press} !== exp) begin
        miscompares++;
        $display("FAIL reset_redetect k=%0d got %b want %b", k, {state, press, release_pulse, long_press}, exp);
      end
    end
    btn_n = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      @(negedge sys_clk);
      exp = {(k >= 6) ? 2'b00 : 2'b11, 2'b00, (k == 6) ? 2'b11 : 2'b00, 2'b00};
      vectors++;
      if ({state, press, release_pulse, long_press} !== exp) begin
        miscompares++;
        $display("FAIL reset_release k=%0d got %b want %b", k, {state, press, release_pulse, long_press}, exp);
      end
    end
  endtask

  task automatic test_clean();
    logic [7:0] exp;
    btn_n = 2'b10;
    for (int k = 1; k <= 8; k++) begin
      @(negedge sys_clk);
      exp = {(k >= 6) ? 2'b01 : 2'b00, (k == 6) ? 2'b01 : 2'b00, 2'b00, 2'b00};
      vectors++;
      if ({state, press, release_pulse, long_press} !== exp) begin
        miscompares++;
        $display("FAIL clean_press k=%0d got %b want %b", k, {state, press, release_pulse, long_press}, exp);
      end
    end
    btn_n = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      @(negedge sys_clk);
      exp = {(k >= 6) ? 2'b00 : 2'b01, 2'b00, (k == 6) ? 2'b01 : 2'b00, 2'b00};
      vectors++;
      if ({state, press, release_pulse, long_press} !== exp) begin
        miscompares++;
        $display("FAIL clean_release k=%0d got %b want %b", k, {state, press, release_pulse, long_press}, exp);
      end
    end
  endtask

  task automatic test_bounce();
    logic [7:0]  exp;
    logic [19:0] pat;
    pat = 20'b11000_10011_10110_00100;
    for (int c = 0; c < 20; c++) begin
      btn_n = {1'b1, pat[c]};
      @(negedge sys_clk);
      vectors++;
      if ({state, press, release_pulse, long_press} !== 8'h00) begin
        miscompares++;
        $display("FAIL bounce_quiet c=%0d got %b want %b", c, {state, press, release_pulse, long_press}, 8'h00);
      end
    end
    btn_n = 2'b10;
    for (int k = 1; k <= 8; k++) begin
      @(negedge sys_clk);
      exp = {(k >= 6) ? 2'b01 : 2'b00, (k == 6) ? 2'b01 : 2'b00, 2'b00, 2'b00};
      vectors++;
      if ({state, press, release_pulse, long_press} !== exp) begin
        miscompares++;
        $display("FAIL bounce_settle k=%0d got %b want %b", k, {state, press, release_pulse, long_press}, exp);
      end
    end
    btn_n = 2'b11;
    repeat (8) @(negedge sys_clk);
  endtask

  task automatic test_long_press();
    logic [7:0] exp;
    btn_n = 2'b01;
    for (int k = 1; k <= 36; k++) begin
      @(negedge sys_clk);
      exp = {(k >= 6) ? 2'b10 : 2'b00, (k == 6) ? 2'b10 : 2'b00, 2'b00, (k == 16) ? 2'b10 : 2'b00};
      vectors++;
      if ({state, press, release_pulse, long_press} !== exp) begin
        miscompares++;
        $display("FAIL long_hold k=%0d got %b want %b", k, {state, press, release_pulse, long_press}, exp);
      end
    end
    btn_n = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      @(negedge sys_clk);
      exp = {(k >= 6) ? 2'b00 : 2'b10, 2'b00, (k == 6) ? 2'b10 : 2'b00, 2'b00};
      vectors++;
      if ({state, press, release_pulse, long_press} !== exp) begin
        miscompares++;
        $display("FAIL long_release k=%0d got %b want %b", k, {state, press, release_pulse, long_press}, exp);
      end
    end
    // Short hold: debounced level stays high for 8 cycles only
    btn_n = 2'b01;
    for (int k = 1; k <= 20; k++) begin
      @(negedge sys_clk);
      exp = {(k >= 6 && k < 14) ? 2'b10 : 2'b00, (k == 6) ? 2'b10 : 2'b00,
             (k == 14) ? 2'b10 : 2'b00, 2'b00};
      vectors++;
      if ({state, press, release_pulse, long_press} !== exp) begin
        miscompares++;
        $display("FAIL short_hold k=%0d got %b want %b", k, {state, press, release_pulse, long_press}, exp);
      end
      if (k == 8) btn_n = 2'b11;
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp;
    btn_n = 2'b00;
    for (int k = 1; k <= 20; k++) begin
      @(negedge sys_clk);
      exp = {(k >= 6) ? 2'b11 : 2'b00, (k == 6) ? 2'b11 : 2'b00, 2'b00, (k == 16) ? 2'b11 : 2'b00};
      vectors++;
      if ({state, press, release_pulse, long_press} !== exp) begin
        miscompares++;
        $display("FAIL simul k=%0d got %b want %b", k, {state, press, release_pulse, long_press}, exp);
      end
    end
    btn_n = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      @(negedge sys_clk);
      exp = {(k >= 6) ? 2'b00 : 2'b11, 2'b00, (k == 6) ? 2'b11 : 2'b00, 2'b00};
      vectors++;
      if ({state, press, release_pulse, long_press} !== exp) begin
        miscompares++;
        $display("FAIL simul_release k=%0d got %b want %b", k, {state, press, release_pulse, long_press}, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp;
    btn_n = 2'b01;
    // After k=13: hc[1]=7 (press at k=6) and dc[0]=2 (ch0 driven at k=9)
    for (int k = 1; k <= 13; k++) begin
      @(negedge sys_clk);
      exp = {(k >= 6) ? 2'b10 : 2'b00, (k == 6) ? 2'b10 : 2'b00, 2'b00, 2'b00};
      vectors++;
      if ({state, press, release_pulse, long_press} !== exp) begin
        miscompares++;
        $display("FAIL mid_setup k=%0d got %b want %b", k, {state, press, release_pulse, long_press}, exp);
      end
      if (k == 9) btn_n = 2'b00;
    end
    #1 sys_rst = 1'b0;
    #1;
    vectors++;
    if ({state, press, release_pulse, long_press} !== 8'h00) begin
      miscompares++;
      $display("FAIL mid_async_clear got %b want %b", {state, press, release_pulse, long_press}, 8'h00);
    end
    repeat (2) begin
      @(negedge sys_clk);
      vectors++;
      if ({state, press, release_pulse, long_press} !== 8'h00) begin
        miscompares++;
        $display("FAIL mid_reset_hold got %b want %b", {state, press, release_pulse, long_press}, 8'h00);
      end
    end
    sys_rst = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge sys_clk);
      exp = {(k >= 6) ? 2'b11 : 2'b00, (k == 6) ? 2'b11 : 2'b00, 2'b00, (k == 16) ? 2'b11 : 2'b00};
      vectors++;
      if ({state, press, release_pulse, long_press} !== exp) begin
        miscompares++;
        $display("FAIL mid_redetect k=%0d got %b want %b", k, {state, press, release_pulse, long_press}, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_bounce();
    test_long_press();
    test_simultaneous();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
